pim_ne_serial: RTL and testbench
================================

Name: pim_ne_serial

Overview:
- Chunk-serial not-equal comparator for the PIM datapath.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and compares it CHUNK bits per cycle, using one CHUNK-wide NE sub-module instance.
- Returns a single NE result over a valid/ready handshake.
- Sits between the operand-fetch stage and the predicate/branch consumer; trades latency for comparator area.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- EARLY_EXIT, 1, 1 = stop scanning at the first differing chunk; 0 = always scan all chunks.
- NCHUNK (localparam), ceil(WIDTH/CHUNK).
- CW (localparam), clog2(NCHUNK+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_ne  out  1  1 when A != B.
- out_chunks  out  CW  number of chunks examined for this result.

Behaviour:
- States: IDLE, SCAN, DONE.
- Reset (async, immediate):
  - state=IDLE, out_valid=0, out_ne=0, out_chunks=0.
  - Operand shift registers and accumulator cleared.
  - in_ready forced 0 while rst is high.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a/in_b into shift registers, acc=0, idx=0, go to SCAN.
- SCAN:
  - in_ready=0. Each cycle the low CHUNK bits of both shift registers feed the NE sub-module, giving chunk_ne.
  - Update: acc<=acc|chunk_ne; shift both registers right by CHUNK; idx<=idx+1.
  - Exit to DONE when idx==NCHUNK-1, or when EARLY_EXIT and chunk_ne=1.
  - On exit: out_ne<=acc|chunk_ne, out_chunks<=idx+1, out_valid<=1.
- DONE:
  - out_valid=1; out_ne and out_chunks held stable.
  - On out_ready, go to IDLE (out_valid<=0) on that edge.
- Latency:
  - Acceptance edge E0, result registered on edge E(n), where n = chunks examined.
  - out_valid is visible in the cycle after E(n).
  - Full scan with default parameters: out_valid high 4 edges after acceptance.
- Throughput: one transaction at a time. in_ready=0 in SCAN and DONE; in_valid is ignored there and the upstream must hold it.
- WIDTH not divisible by CHUNK: the final chunk is zero-padded identically on both operands, so padding never produces NE.
- CHUNK==WIDTH: single SCAN cycle; out_chunks=1.
- Backpressure: out_ready low in DONE holds all outputs indefinitely.
- out_ready high in any state other than DONE has no effect.
- Reset mid-SCAN or mid-DONE aborts the transaction with no partial result emitted. The first cycle after release is IDLE with in_ready=1.
- out_ne/out_chunks retain their last values after leaving DONE. They are only meaningful while out_valid=1.

Decomposition:
- Shared package pim_pkg:
  - state encoding constants (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - clog2 and ceil-div constant functions, reused by other PIM serial blocks.
- Sub-module: the team's existing n-bit NE comparator, instantiated once with WIDTH=CHUNK on the low chunk slices.
- Everything else (FSM, shift registers, counter) stays flat in pim_ne_serial.

Test Plan:
1. Defaults; in_a=in_b=32'h12345678; out_ready=1.
   -> out_valid rises 4 edges after acceptance; out_ne=0, out_chunks=4; in_ready returns to 1 the cycle after the result handshake.
2. Defaults; in_a=32'h80000000, in_b=0.
   -> out_ne=1, out_chunks=4 (difference only in the last chunk).
3. Defaults; in_a=32'h00000001, in_b=0.
   -> early exit: out_valid 1 edge after acceptance, out_ne=1, out_chunks=1. Repeat with EARLY_EXIT=0 -> out_ne=1, out_chunks=4.
4. Backpressure: case 2 with out_ready=0 for 3 cycles after out_valid.
   -> out_valid, out_ne=1, out_chunks=4 stable for all 3 cycles; in_ready=0 throughout; a concurrent in_valid pair (A=5, B=5) is not consumed until after the handshake, then yields out_ne=0.
5. Reset mid-operation: assert rst during the 2nd SCAN cycle of case 1.
   -> out_valid=0 and in_ready=0 immediately (async); after release in_ready=1; next pair A=7, B=6 gives out_ne=1, out_chunks=1.
6. WIDTH=20, CHUNK=8 (NCHUNK=3); in_a=20'hF0000, in_b=20'h70000.
   -> out_ne=1, out_chunks=3. Same with in_a=in_b=20'hFFFFF -> out_ne=0, out_chunks=3 (padding clean).

Source files
------------

// File: rtl/pim_pkg.sv
// Shared PIM serial-block definitions: FSM state encodings and
// elaboration-time helper functions used to size counters and chunk loops.
package pim_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of bits needed to hold values 0..n-1 (ceiling log2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Integer division rounded up.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/pim_ne_serial_cmp.sv
// Combinational n-bit not-equal comparator: ne is 1 when any bit differs.
module pim_ne_serial_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ne
);

  logic [WIDTH-1:0] diff;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign diff[gi] = a[gi] ^ b[gi];
  end

  assign ne = |diff;

endmodule

// File: rtl/pim_ne_serial.sv
// Chunk-serial not-equal comparator. An operand pair is accepted over a
// valid/ready handshake, compared CHUNK bits per cycle through a single
// CHUNK-wide comparator, and a single NE result is returned over a second
// valid/ready handshake together with the number of chunks examined.
module pim_ne_serial
  import pim_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1,
  localparam int NCHUNK    = ceil_div(WIDTH, CHUNK),
  localparam int CW        = clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ne,
  output logic [CW-1:0]    out_chunks
);

  // Shift registers are padded up to a whole number of chunks; the padding
  // is zero on both operands so it can never report a difference.
  localparam int PW = NCHUNK * CHUNK;

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] a_sh_reg, a_sh_next;
  logic [PW-1:0] b_sh_reg, b_sh_next;
  logic          acc_reg, acc_next;
  logic [CW-1:0] idx_reg, idx_next;
  logic          out_ne_reg, out_ne_next;
  logic [CW-1:0] out_chunks_reg, out_chunks_next;

  logic chunk_ne;
  logic last_chunk;
  logic scan_exit;

  pim_ne_serial_cmp #(
    .WIDTH(CHUNK)
  ) u_cmp (
    .a  (a_sh_reg[CHUNK-1:0]),
    .b  (b_sh_reg[CHUNK-1:0]),
    .ne (chunk_ne)
  );

  assign last_chunk = (idx_reg == CW'(NCHUNK - 1));
  assign scan_exit  = last_chunk || ((EARLY_EXIT != 0) && chunk_ne);

  // in_ready is gated by rst so it drops combinationally during reset.
  assign in_ready   = (state_reg == ST_IDLE) && !rst;
  assign out_valid  = (state_reg == ST_DONE);
  assign out_ne     = out_ne_reg;
  assign out_chunks = out_chunks_reg;

  // Next-state logic for the FSM, operand shifters, accumulator and counter.
  always_comb begin
    state_next      = state_reg;
    a_sh_next       = a_sh_reg;
    b_sh_next       = b_sh_reg;
    acc_next        = acc_reg;
    idx_next        = idx_reg;
    out_ne_next     = out_ne_reg;
    out_chunks_next = out_chunks_reg;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_next  = PW'(in_a);
          b_sh_next  = PW'(in_b);
          acc_next   = 1'b0;
          idx_next   = '0;
          state_next = ST_SCAN;
        end
      end

      ST_SCAN: begin
        acc_next  = acc_reg | chunk_ne;
        a_sh_next = a_sh_reg >> CHUNK;
        b_sh_next = b_sh_reg >> CHUNK;
        idx_next  = idx_reg + CW'(1);
        if (scan_exit) begin
          out_ne_next     = acc_reg | chunk_ne;
          out_chunks_next = idx_reg + CW'(1);
          state_next      = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset aborting any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      acc_reg        <= 1'b0;
      idx_reg        <= '0;
      out_ne_reg     <= 1'b0;
      out_chunks_reg <= '0;
    end else begin
      state_reg      <= state_next;
      a_sh_reg       <= a_sh_next;
      b_sh_reg       <= b_sh_next;
      acc_reg        <= acc_next;
      idx_reg        <= idx_next;
      out_ne_reg     <= out_ne_next;
      out_chunks_reg <= out_chunks_next;
    end
  end

endmodule

// File: tb/tb_pim_ne_serial.sv
// Testbench for pim_ne_serial: three instances (defaults, no early exit,
// WIDTH=20) driven one transaction at a time with a scoreboard queue.
module tb_pim_ne_serial;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus (index 0: defaults, 1: EARLY_EXIT=0, 2: WIDTH=20)
  logic [2:0]  in_valid_v  = 3'b000;
  logic [2:0]  out_ready_v = 3'b111;
  logic [31:0] in_a_v [3];
  logic [31:0] in_b_v [3];

  logic ir0, ir1, ir2, ov0, ov1, ov2, ne0, ne1, ne2;
  logic [2:0] oc0, oc1;
  logic [1:0] oc2;

  wire [2:0] in_ready_v  = {ir2, ir1, ir0};
  wire [2:0] out_valid_v = {ov2, ov1, ov0};
  wire [2:0] out_ne_v    = {ne2, ne1, ne0};
  logic [2:0] out_chunks_v [3];
  assign out_chunks_v[0] = oc0;
  assign out_chunks_v[1] = oc1;
  assign out_chunks_v[2] = {1'b0, oc2};

  pim_ne_serial #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .in_a(in_a_v[0]), .in_b(in_b_v[0]), .out_valid(ov0),
    .out_ready(out_ready_v[0]), .out_ne(ne0), .out_chunks(oc0));

  pim_ne_serial #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .in_a(in_a_v[1]), .in_b(in_b_v[1]), .out_valid(ov1),
    .out_ready(out_ready_v[1]), .out_ne(ne1), .out_chunks(oc1));

  pim_ne_serial #(.WIDTH(20), .CHUNK(8), .EARLY_EXIT(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .in_a(in_a_v[2][19:0]), .in_b(in_b_v[2][19:0]), .out_valid(ov2),
    .out_ready(out_ready_v[2]), .out_ne(ne2), .out_chunks(oc2));

  typedef struct packed {
    logic       ne;
    logic [2:0] chunks;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: NE over the instance width, chunks = first differing chunk
  // (with early exit) or the full chunk count.
  function automatic exp_t model(input int sel, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int w;
    int nch;
    logic [31:0] am, bm, mask;
    logic found;
    w     = (sel == 2) ? 20 : 32;
    nch   = (w + 7) / 8;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am    = a & mask;
    bm    = b & mask;
    r.ne  = (am != bm);
    r.chunks = 3'(nch);
    found = 1'b0;
    for (int i = 0; i < nch; i++) begin
      if (!found && (am[i*8 +: 8] != bm[i*8 +: 8])) begin
        found = 1'b1;
        if (sel != 1) r.chunks = 3'(i + 1);
      end
    end
    return r;
  endfunction

  // One full transaction; starts and ends in the low clock phase.
  // hold = cycles out_ready stays low after out_valid; pend = present a
  // 5/5 operand pair while the result is held back.
  task automatic run_txn(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit pend);
    int n;
    int lat;
    bit seen;
    exp_t e;
    in_a_v[sel] = a;
    in_b_v[sel] = b;
    in_valid_v[sel] = 1'b1;
    out_ready_v[sel] = (hold == 0);
    n = 0;
    while (!in_ready_v[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_v[sel]) begin
      checks++; errors++;
      $display("FAIL accept_timeout sel=%0d: in_ready got 0 required 1", sel);
      in_valid_v[sel] = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(model(sel, a, b));
    #1 in_valid_v[sel] = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_v[sel]) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL result_timeout sel=%0d: out_valid got 0 required 1", sel);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    $display("txn sel=%0d a=%h b=%h ne=%0d chunks=%0d latency=%0d", sel, a, b,
             out_ne_v[sel], out_chunks_v[sel], lat);
    if (lat !== int'(e.chunks)) begin
      errors++;
      $display("FAIL latency sel=%0d: got %0d required %0d", sel, lat, e.chunks);
    end
    checks++;
    if (out_ne_v[sel] !== e.ne) begin
      errors++;
      $display("FAIL out_ne sel=%0d: got %0d required %0d", sel, out_ne_v[sel], e.ne);
    end
    checks++;
    if (out_chunks_v[sel] !== e.chunks) begin
      errors++;
      $display("FAIL out_chunks sel=%0d: got %0d required %0d", sel, out_chunks_v[sel], e.chunks);
    end
    checks++;
    if (in_ready_v[sel] !== 1'b0) begin
      errors++;
      $display("FAIL in_ready_done sel=%0d: got %0d required 0", sel, in_ready_v[sel]);
    end
    if (pend) begin
      in_a_v[sel] = 32'd5;
      in_b_v[sel] = 32'd5;
      in_valid_v[sel] = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid_v[sel] !== 1'b1 || out_ne_v[sel] !== e.ne ||
          out_chunks_v[sel] !== e.chunks || in_ready_v[sel] !== 1'b0) begin
        errors++;
        $display("FAIL hold sel=%0d cyc=%0d: got v=%0d ne=%0d ch=%0d rdy=%0d required v=1 ne=%0d ch=%0d rdy=0",
                 sel, h, out_valid_v[sel], out_ne_v[sel], out_chunks_v[sel], in_ready_v[sel],
                 e.ne, e.chunks);
      end
    end
    out_ready_v[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid_v[sel] !== 1'b0 || in_ready_v[sel] !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake sel=%0d: got v=%0d rdy=%0d required v=0 rdy=1",
               sel, out_valid_v[sel], in_ready_v[sel]);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready_v !== 3'b000 || out_valid_v !== 3'b000 || out_ne_v !== 3'b000 ||
        out_chunks_v[0] !== 3'd0 || out_chunks_v[2] !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b ne=%b ch0=%0d required rdy=000 v=000 ne=000 ch0=0",
               in_ready_v, out_valid_v, out_ne_v, out_chunks_v[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_v !== 3'b111) begin
      errors++;
      $display("FAIL reset_release: in_ready got %b required 111", in_ready_v);
    end
    @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_basic;
    run_txn(0, 32'h1234_5678, 32'h1234_5678, 0, 1'b0);
    run_txn(0, 32'h8000_0000, 32'h0000_0000, 0, 1'b0);
    run_txn(0, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
    run_txn(0, 32'h0001_0000, 32'h0000_0000, 0, 1'b0);
  endtask

  task automatic test_no_early_exit;
    run_txn(1, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
    run_txn(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_txn(0, 32'h8000_0000, 32'h0000_0000, 3, 1'b1);
    run_txn(0, 32'd5, 32'd5, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    // Abort during the second SCAN cycle.
    in_a_v[0] = 32'h1234_5678;
    in_b_v[0] = 32'h1234_5678;
    in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: got v=%0d rdy=%0d required v=0 rdy=0", out_valid_v[0], in_ready_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: in_ready got %0d required 1", in_ready_v[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL no_partial cyc=%0d: out_valid got %0d required 0", i, out_valid_v[0]);
      end
    end
    $display("reset mid-scan done");
    // Abort while a result waits in DONE.
    in_a_v[0] = 32'h0000_00FF;
    in_b_v[0] = 32'h0000_0000;
    in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b0;
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_done: out_valid got %0d required 1", out_valid_v[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0 || out_ne_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: got v=%0d rdy=%0d ne=%0d required v=0 rdy=0 ne=0",
               out_valid_v[0], in_ready_v[0], out_ne_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready_v[0] = 1'b1;
    #1;
    $display("reset mid-done done");
    run_txn(0, 32'd7, 32'd6, 0, 1'b0);
  endtask

  task automatic test_odd_width;
    run_txn(2, 32'h000F_0000, 32'h0007_0000, 0, 1'b0);
    run_txn(2, 32'h000F_FFFF, 32'h000F_FFFF, 0, 1'b0);
    run_txn(2, 32'h0000_0100, 32'h0000_0000, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : (a ^ (32'd1 << $urandom_range(0, 31)));
      run_txn(i % 3, a, b, $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    in_a_v[0] = '0; in_a_v[1] = '0; in_a_v[2] = '0;
    in_b_v[0] = '0; in_b_v[1] = '0; in_b_v[2] = '0;
    test_reset();
    test_basic();
    test_no_early_exit();
    test_backpressure();
    test_reset_mid();
    test_odd_width();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
